// File: rtl/phy_mdio_ctrl.sv
// RGMII PHY bring-up sequencer: reset pulse, Clause-22 MDIO configuration writes,
// then endless status polling with link reporting.
module phy_mdio_ctrl #(
    parameter int          MDC_DIV      = 25,
    parameter int          RST_HOLD_CYC = 1250000,
    parameter int          RST_WAIT_CYC = 6250000,
    parameter int          POLL_CYC     = 1250000,
    parameter logic [4:0]  PHY_ADDR     = 5'h01,
    parameter int          NUM_CFG      = 2,
    parameter logic [83:0] CFG_TABLE    = {21'h0, 21'h0, 5'h14, 16'h0C82, 5'h00, 16'h1140},
    parameter logic [4:0]  STATUS_REG   = 5'h01,
    parameter int          LINK_BIT     = 2
) (
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        mdioIn,
    output logic        mdioOut,
    output logic        mdioOeOut,
    output logic        mdcOut,
    output logic        phyRstBOut,
    output logic        cfgDoneOut,
    output logic        linkUpOut,
    output logic [15:0] statusOut,
    output logic        busyOut
);

    typedef enum logic [2:0] {
        RST_HOLD  = 3'd0,
        RST_WAIT  = 3'd1,
        CFG       = 3'd2,
        POLL      = 3'd3,
        POLL_WAIT = 3'd4
    } state_t;

    state_t      state;
    state_t      nextState;
    logic [31:0] waitCnt;
    logic [9:0]  gapCnt;
    logic [2:0]  cfgIdx;
    logic [7:0]  divCnt;
    logic [5:0]  bitIdx;
    logic [63:0] frameSh;
    logic [15:0] rdSh;
    logic        isRead;

    logic        tick;
    logic        frameEnd;
    logic        startFrame;
    logic [20:0] cfgEntrySel;
    logic [63:0] frameWord;

    function automatic logic [20:0] cfgEntry(input logic [1:0] idx);
        case (idx)
            2'd0:    return CFG_TABLE[20:0];
            2'd1:    return CFG_TABLE[41:21];
            2'd2:    return CFG_TABLE[62:42];
            2'd3:    return CFG_TABLE[83:63];
            default: return 21'h0;
        endcase
    endfunction

    // Frame timing strobes and the frame to launch next
    always_comb begin
        tick        = busyOut && (divCnt == 8'(MDC_DIV - 1));
        frameEnd    = tick && mdcOut && (bitIdx == 6'd63);
        startFrame  = ((state == CFG) || (state == POLL)) && !busyOut
                      && (gapCnt == 10'(2 * MDC_DIV - 1));
        cfgEntrySel = cfgEntry(cfgIdx[1:0]);
        if (state == POLL) begin
            frameWord = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, STATUS_REG, 2'b11, 16'hFFFF};
        end else begin
            frameWord = {32'hFFFF_FFFF, 2'b01, 2'b01, PHY_ADDR, cfgEntrySel[20:16],
                         2'b10, cfgEntrySel[15:0]};
        end
    end

    // Next-state logic of the bring-up sequence
    always_comb begin
        nextState = state;
        case (state)
            RST_HOLD: begin
                if (waitCnt == 32'(RST_HOLD_CYC - 1)) begin
                    nextState = RST_WAIT;
                end else begin
                    nextState = RST_HOLD;
                end
            end
            RST_WAIT: begin
                if (waitCnt == 32'(RST_WAIT_CYC - 1)) begin
                    nextState = (NUM_CFG == 0) ? POLL : CFG;
                end else begin
                    nextState = RST_WAIT;
                end
            end
            CFG: begin
                if (frameEnd && (cfgIdx == 3'(NUM_CFG - 1))) begin
                    nextState = POLL;
                end else begin
                    nextState = CFG;
                end
            end
            POLL: begin
                if (frameEnd) begin
                    nextState = POLL_WAIT;
                end else begin
                    nextState = POLL;
                end
            end
            POLL_WAIT: begin
                if (waitCnt == 32'(POLL_CYC - 1)) begin
                    nextState = POLL;
                end else begin
                    nextState = POLL_WAIT;
                end
            end
            default: nextState = RST_HOLD;
        endcase
    end

    // State register
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state <= RST_HOLD;
        end else begin
            state <= nextState;
        end
    end

    // Delay counter for the timed states and the idle gap ahead of each frame
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            waitCnt <= 32'd0;
            gapCnt  <= 10'd0;
        end else begin
            if ((state != nextState) || (state == CFG) || (state == POLL)) begin
                waitCnt <= 32'd0;
            end else begin
                waitCnt <= waitCnt + 32'd1;
            end
            if (busyOut || startFrame || !((state == CFG) || (state == POLL))) begin
                gapCnt <= 10'd0;
            end else begin
                gapCnt <= gapCnt + 10'd1;
            end
        end
    end

    // Sequence outputs: PHY reset release, config progress, status capture
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            phyRstBOut <= 1'b0;
            cfgDoneOut <= 1'b0;
            linkUpOut  <= 1'b0;
            statusOut  <= 16'h0000;
            cfgIdx     <= 3'd0;
        end else begin
            if ((state == RST_HOLD) && (nextState == RST_WAIT)) begin
                phyRstBOut <= 1'b1;
            end
            if (((state == RST_WAIT) || (state == CFG)) && (nextState == POLL)) begin
                cfgDoneOut <= 1'b1;
            end
            if ((state == CFG) && frameEnd) begin
                cfgIdx <= cfgIdx + 3'd1;
            end
            if ((state == POLL) && frameEnd) begin
                statusOut <= rdSh;
                linkUpOut <= rdSh[LINK_BIT];
            end
        end
    end

    // MDIO frame engine: MDC divider, bit shifter, turnaround and read capture
    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            busyOut   <= 1'b0;
            mdcOut    <= 1'b0;
            mdioOut   <= 1'b1;
            mdioOeOut <= 1'b0;
            divCnt    <= 8'd0;
            bitIdx    <= 6'd0;
            frameSh   <= 64'h0;
            rdSh      <= 16'h0000;
            isRead    <= 1'b0;
        end else if (startFrame) begin
            busyOut   <= 1'b1;
            mdcOut    <= 1'b0;
            mdioOut   <= frameWord[63];
            mdioOeOut <= 1'b1;
            divCnt    <= 8'd0;
            bitIdx    <= 6'd0;
            frameSh   <= {frameWord[62:0], 1'b0};
            rdSh      <= 16'h0000;
            isRead    <= (state == POLL);
        end else if (tick) begin
            divCnt <= 8'd0;
            if (!mdcOut) begin
                mdcOut <= 1'b1;
                if (isRead && (bitIdx >= 6'd48)) begin
                    rdSh <= {rdSh[14:0], mdioIn};
                end
            end else if (bitIdx == 6'd63) begin
                mdcOut    <= 1'b0;
                busyOut   <= 1'b0;
                mdioOeOut <= 1'b0;
                mdioOut   <= 1'b1;
            end else begin
                mdcOut  <= 1'b0;
                bitIdx  <= bitIdx + 6'd1;
                mdioOut <= frameSh[63];
                frameSh <= {frameSh[62:0], 1'b0};
                // release the line for the PHY's turnaround from bit 46 on
                if (isRead && (bitIdx == 6'd45)) begin
                    mdioOeOut <= 1'b0;
                end
            end
        end else if (busyOut) begin
            divCnt <= divCnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_phy_mdio_ctrl.sv
// Bench for phy_mdio_ctrl: two instances (config+poll at MDC_DIV=2, poll-only at MDC_DIV=1)
// with a PHY model and a frame scoreboard.
module tb_phy_mdio_ctrl;

    typedef struct {
        logic [63:0] word;
        logic        isRead;
        logic [15:0] data;
        logic        cfgDone;
    } exp_t;

    logic clk = 1'b0;
    logic rstIn = 1'b1;
    int   testCnt = 0;
    int   failCnt = 0;

    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCnt++;
        if (got !== exp) begin
            failCnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t expFrame(input int inst, input int s);
        exp_t e;
        e.cfgDone = 1'b1;
        e.isRead  = 1'b1;
        if (inst == 0) begin
            e.data = (s == 2) ? 16'h796D : 16'h7969;
            if (s == 0) begin
                e.isRead  = 1'b0;
                e.data    = 16'h1140;
                e.cfgDone = 1'b0;
                e.word    = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h00, 2'b10, 16'h1140};
            end else if (s == 1) begin
                e.isRead = 1'b0;
                e.data   = 16'h0C82;
                e.word   = {32'hFFFF_FFFF, 2'b01, 2'b01, 5'h01, 5'h14, 2'b10, 16'h0C82};
            end else begin
                e.word = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h01, 2'b11, e.data};
            end
        end else begin
            e.data = ((s % 2) == 0) ? 16'h0004 : 16'h8001;
            e.word = {32'hFFFF_FFFF, 2'b01, 2'b10, 5'h01, 5'h01, 2'b11, e.data};
        end
        return e;
    endfunction

    for (genvar i = 0; i < 2; i++) begin : g
        localparam int DIV  = (i == 0) ? 2 : 1;
        localparam int NCFG = (i == 0) ? 2 : 0;
        localparam int PCYC = (i == 0) ? 40 : 30;

        logic        mdioIn, mdioOut, oe, mdc, phyRst, cfgDone, linkUp, busy;
        logic [15:0] status;
        logic        phyDrive = 1'b1;
        logic        prevBusy = 1'b0, prevMdc = 1'b0, prevOe = 1'b0, lastWasRead = 1'b0;
        logic [63:0] word = 64'h0;
        int          seq = 0, bitCnt = 0, oeFall = 99, nDone = 0;
        int          relCyc = 0, lastRise = 0, lastEnd = 0;
        exp_t        q[$];
        exp_t        cur;
        exp_t        e;

        assign mdioIn = oe ? mdioOut : phyDrive;

        phy_mdio_ctrl #(
            .MDC_DIV(DIV), .RST_HOLD_CYC(10), .RST_WAIT_CYC(20), .POLL_CYC(PCYC),
            .PHY_ADDR(5'h01), .NUM_CFG(NCFG), .STATUS_REG(5'h01), .LINK_BIT(2)
        ) dut (
            .clkIn(clk), .rstIn(rstIn), .mdioIn(mdioIn), .mdioOut(mdioOut),
            .mdioOeOut(oe), .mdcOut(mdc), .phyRstBOut(phyRst), .cfgDoneOut(cfgDone),
            .linkUpOut(linkUp), .statusOut(status), .busyOut(busy)
        );

        // PHY model, frame decoder and scoreboard, sampled 1 time unit after each edge
        always @(posedge clk) begin
            #1;
            if (rstIn) begin
                seq = 0; nDone = 0; relCyc = 0; q.delete(); phyDrive = 1'b1; lastWasRead = 1'b0;
            end else begin
                relCyc++;
                if (busy && !prevBusy) begin
                    cur = expFrame(i, seq);
                    q.push_back(cur);
                    bitCnt = 0; oeFall = 99; phyDrive = 1'b1; word = 64'h0;
                    if (seq == 0) checkVal($sformatf("firstBusy%0d", i), 64'(relCyc >= 30), 64'd1);
                    else if (lastWasRead) checkVal($sformatf("pollGap%0d", i), 64'(relCyc - lastEnd), 64'(PCYC + 2 * DIV));
                    seq++;
                end
                if (mdc && !prevMdc) begin
                    word = {word[62:0], mdioIn};
                    bitCnt++;
                    if (bitCnt == 2) checkVal($sformatf("mdcPeriod%0d", i), 64'(relCyc - lastRise), 64'(2 * DIV));
                    lastRise = relCyc;
                end
                if (!mdc && prevMdc && busy) begin
                    phyDrive = (bitCnt >= 48 && bitCnt < 64) ? cur.data[63 - bitCnt] : 1'b1;
                end
                if (!oe && prevOe && busy) oeFall = bitCnt;
                if (!busy && prevBusy) begin
                    if (q.size() == 0) begin
                        checkVal($sformatf("sbEmpty%0d", i), 64'd1, 64'd0);
                    end else begin
                        e = q.pop_front();
                        checkVal($sformatf("frameWord%0d_%0d", i, nDone), word, e.word);
                        checkVal($sformatf("frameBits%0d", i), 64'(bitCnt), 64'd64);
                        checkVal($sformatf("oeFallBit%0d", i), 64'(oeFall), e.isRead ? 64'd46 : 64'd99);
                        checkVal($sformatf("cfgDone%0d", i), 64'(cfgDone), 64'(e.cfgDone));
                        if (e.isRead) begin
                            checkVal($sformatf("status%0d", i), 64'(status), 64'(e.data));
                            checkVal($sformatf("linkUp%0d", i), 64'(linkUp), 64'(e.data[2]));
                        end
                        lastWasRead = e.isRead;
                    end
                    nDone++;
                    lastEnd = relCyc;
                end
            end
            prevBusy = busy; prevMdc = mdc; prevOe = oe;
        end
    end

    task automatic waitDone(input int target, input string tag);
        int n = 0;
        while (g[0].nDone < target && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) checkVal(tag, 64'd0, 64'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkVal({tag, "PhyRst"}, 64'(g[0].phyRst), 64'd0);
        checkVal({tag, "Mdc"}, 64'(g[0].mdc), 64'd0);
        checkVal({tag, "Oe"}, 64'(g[0].oe), 64'd0);
        checkVal({tag, "Busy"}, 64'(g[0].busy), 64'd0);
        checkVal({tag, "CfgDone"}, 64'(g[0].cfgDone), 64'd0);
        checkVal({tag, "Mdio"}, 64'(g[0].mdioOut), 64'd1);
        checkVal({tag, "LinkUp"}, 64'(g[0].linkUp), 64'd0);
        checkVal({tag, "Status"}, 64'(g[0].status), 64'd0);
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        checkResetOutputs("rstA");
        checkVal("rstBPhyRst", 64'(g[1].phyRst), 64'd0);
        checkVal("rstBCfgDone", 64'(g[1].cfgDone), 64'd0);
        checkVal("rstBMdio", 64'(g[1].mdioOut), 64'd1);
        @(negedge clk);
        rstIn = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (g[0].phyRst) break;
        end
        checkVal("rstHoldCycles", 64'(n), 64'd10);

        waitDone(4, "timeoutFirstRun");

        n = 0;
        while (!(g[0].busy && g[0].bitCnt == 40) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) checkVal("timeoutBit40", 64'd0, 64'd1);
        rstIn = 1'b1;
        @(posedge clk);
        #1;
        checkResetOutputs("abort");
        @(negedge clk);
        rstIn = 1'b0;

        waitDone(3, "timeoutRestart");
        checkVal("restartCfgDone", 64'(g[0].cfgDone), 64'd1);
        checkVal("restartLinkUp", 64'(g[0].linkUp), 64'd1);

        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
